operand_seq_ctrl: RTL
=====================

Name: operand_seq_ctrl

Overview:
- Front-panel sequencer for the ALU board.
- Turns two pushbuttons (NEXT, CLR) into the select and strobe sequence for the operand-routing mux:
  - select lines SW_SEL
  - SET and RESET pulses
  - the operation-start handshake
- Sits between board keys and the operand mux/ALU; replaces raw switch control of operand entry.

Parameters:
- DEB_CYCLES, 50000, consecutive stable clocks required to accept a key level change.
- TIMEOUT, 1024, max clocks to wait for ALU_DONE after START.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- KEY_NEXT  in  1  raw async button, active-high after board inversion; advance step.
- KEY_CLR  in  1  raw async button, active-high; clear current operand / abort.
- ALU_DONE  in  1  one-cycle pulse from ALU, result valid.
- SW_SEL  out  2  mux select: 00 route entry to A, 01 route to B, 10 hold/result.
- SET  out  1  one-cycle load strobe to the selected operand register.
- RESET  out  1  one-cycle clear strobe to the selected operand register.
- START  out  1  one-cycle ALU start pulse.
- BUSY  out  1  high while waiting for ALU_DONE.
- ERR  out  1  sticky timeout flag.
- STEP  out  3  current state code, for LEDs.

Behaviour:
- Clock and reset: single clock CLK; synchronous active-high reset RST.
- Key conditioning:
  - Each key passes a 2-FF synchronizer, then a debouncer.
  - Debouncer: filtered level updates only after the synced level differs from it for DEB_CYCLES consecutive clocks; any bounce restarts the count.
  - Press event = one-cycle pulse on filtered rising edge. Release produces no event.
  - Latency from clean key edge to event: DEB_CYCLES+3 clocks.
- FSM (registered). Outputs are decoded from the current state only.
- States (STEP code: SW_SEL, strobes):
  - LOAD_A (0): SW_SEL=00, no strobes.
  - COMMIT_A (1): SW_SEL=00, SET=1.
  - LOAD_B (2): SW_SEL=01.
  - COMMIT_B (3): SW_SEL=01, SET=1.
  - RUN_START (4): SW_SEL=10, START=1, BUSY=1.
  - RUN_WAIT (5): SW_SEL=10, BUSY=1.
  - SHOW (6): SW_SEL=10.
  - CLR_X (7): SW_SEL=value held from originating state, RESET=1.
- Transitions:
  - LOAD_A: CLR event -> CLR_X (sel 00). Else NEXT event -> COMMIT_A.
  - COMMIT_A -> LOAD_B unconditionally (SET lasts exactly 1 cycle while SW_SEL is still 00).
  - LOAD_B: CLR event -> CLR_X (sel 01). Else NEXT event -> COMMIT_B.
  - COMMIT_B -> RUN_START.
  - RUN_START -> RUN_WAIT; timeout counter loads 0.
  - RUN_WAIT:
    - ALU_DONE -> SHOW.
    - Counter reaching TIMEOUT-1 without DONE -> SHOW with ERR<=1.
    - ALU_DONE takes priority when it arrives on the terminal count cycle.
    - Key events are ignored (dropped, not queued).
  - SHOW: NEXT or CLR event -> LOAD_A; ERR cleared on that transition.
  - CLR_X -> returns to the originating LOAD state.
- Simultaneous NEXT and CLR events: CLR wins.
- ALU_DONE outside RUN_WAIT is ignored.
- SET, RESET and START are never asserted together; each is high for at most 1 cycle per event.
- Reset values:
  - FSM: state LOAD_A; SW_SEL=00; STEP=0.
  - Strobes and flags: SET=RESET=START=BUSY=ERR=0.
  - Conditioning: debounce counters and filtered levels 0; sync FFs 0.
  - Timeout counter 0.
- Reset mid-operation (including RUN_WAIT) aborts immediately; a pending ALU_DONE is then ignored.
- Counter widths: $clog2 of the parameter; DEB_CYCLES >= 1 and TIMEOUT >= 2 required.

Optional Feature:
- Macro: OPSEQ_DEBOUNCE_EN.
- Defined: debouncer as above.
- Undefined: debouncer removed; event = rising edge of the synchronized level; key-to-event latency 3 clocks; DEB_CYCLES unused.

Test Plan:
- Reset check (DEB_CYCLES=4, TIMEOUT=8): assert RST 2 cycles -> STEP=0, SW_SEL=00, all strobes 0, ERR=0.
- Clean NEXT press held 10 clocks in LOAD_A:
  - Event fires 7 clocks after the edge.
  - Next cycle: SET=1 with SW_SEL=00 for exactly 1 cycle.
  - Then STEP=2, SW_SEL=01.
- Full sequence with ALU_DONE pulsed 3 cycles after START:
  - Two SET pulses, SEL 00 then 01.
  - START one cycle with SEL=10; BUSY for 4 cycles.
  - STEP=6, ERR=0.
  - NEXT -> STEP=0.
- Bouncy KEY_NEXT (toggling every 2 clocks for 12 clocks, then stable high) -> exactly one SET pulse.
- KEY_CLR in LOAD_B: RESET=1 one cycle with SW_SEL=01, then STEP=2. Same-cycle NEXT+CLR events -> RESET only, no SET.
- No ALU_DONE after START:
  - SHOW entered 8 cycles after RUN_WAIT entry; ERR=1.
  - ERR stays 1 until NEXT returns to LOAD_A.
- DONE arriving exactly on the terminal count cycle -> SHOW with ERR=0.

Source files
------------

// File: rtl/operand_seq_ctrl.sv
// operand_seq_ctrl: front-panel sequencer for the ALU board.
// Two pushbuttons (NEXT, CLR) step the operand-routing mux through
// A entry, B entry, ALU run and result display.
// Build option: define OPSEQ_DEBOUNCE_EN to place a DEB_CYCLES debouncer
// after each key synchronizer. Without it, an event is the rising edge of
// the synchronized key and DEB_CYCLES is not used.

// Key conditioning: 2-FF synchronizer, optional debouncer, rising-edge pulse.
module opseq_key_cond
`ifdef OPSEQ_DEBOUNCE_EN
  #(parameter int DEB_CYCLES = 50000)
`endif
  (
  input  logic CLK,
  input  logic RST,
  input  logic key_i,
  output logic evt_o
);
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic evt_q;
  logic lvl_s;

  // Bring the asynchronous key level into the CLK domain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef OPSEQ_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic [DW-1:0] deb_cnt_q;
  logic          filt_q;

  // Accept a new level only after it has differed for DEB_CYCLES clocks in a row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      deb_cnt_q <= '0;
      filt_q    <= 1'b0;
    end else if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_q    <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_ONE;
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  assign lvl_s = filt_q;
`else
  assign lvl_s = sync2_q;
`endif

  // One-cycle event on the rising edge of the conditioned level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      prev_q <= lvl_s;
      evt_q  <= lvl_s & ~prev_q;
    end
  end

  assign evt_o = evt_q;
endmodule

module operand_seq_ctrl #(
  parameter int DEB_CYCLES = 50000,
  parameter int TIMEOUT    = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_NEXT,
  input  logic       KEY_CLR,
  input  logic       ALU_DONE,
  output logic [1:0] SW_SEL,
  output logic       SET,
  output logic       RESET,
  output logic       START,
  output logic       BUSY,
  output logic       ERR,
  output logic [2:0] STEP
);
  typedef enum logic [2:0] {
    LOAD_A    = 3'd0,
    COMMIT_A  = 3'd1,
    LOAD_B    = 3'd2,
    COMMIT_B  = 3'd3,
    RUN_START = 3'd4,
    RUN_WAIT  = 3'd5,
    SHOW      = 3'd6,
    CLR_X     = 3'd7
  } state_e;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  if (DEB_CYCLES < 1 || TIMEOUT < 2) begin : g_param_check
    $error("operand_seq_ctrl: DEB_CYCLES must be >= 1 and TIMEOUT >= 2");
  end

  logic next_evt_s;
  logic clr_evt_s;

  opseq_key_cond
`ifdef OPSEQ_DEBOUNCE_EN
    #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_key_next (.CLK(CLK), .RST(RST), .key_i(KEY_NEXT), .evt_o(next_evt_s));

  opseq_key_cond
`ifdef OPSEQ_DEBOUNCE_EN
    #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_key_clr (.CLK(CLK), .RST(RST), .key_i(KEY_CLR), .evt_o(clr_evt_s));

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          from_b_q, from_b_d;   // CLR_X was entered from LOAD_B
  logic          err_q, err_d;
  logic [1:0]    sel_q, sel_d;
  logic          set_q, set_d;
  logic          rst_q, rst_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;

  // Next state, timeout counter and sticky error; CLR beats NEXT.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    from_b_d = from_b_q;
    err_d    = err_q;
    case (state_q)
      LOAD_A: begin
        if (clr_evt_s) begin
          state_d  = CLR_X;
          from_b_d = 1'b0;
        end else if (next_evt_s) begin
          state_d = COMMIT_A;
        end else begin
          state_d = LOAD_A;
        end
      end
      COMMIT_A:  state_d = LOAD_B;
      LOAD_B: begin
        if (clr_evt_s) begin
          state_d  = CLR_X;
          from_b_d = 1'b1;
        end else if (next_evt_s) begin
          state_d = COMMIT_B;
        end else begin
          state_d = LOAD_B;
        end
      end
      COMMIT_B:  state_d = RUN_START;
      RUN_START: begin
        state_d = RUN_WAIT;
        tmo_d   = '0;
      end
      RUN_WAIT: begin
        if (ALU_DONE) begin
          state_d = SHOW;
        end else if (tmo_q == TMO_LAST) begin
          state_d = SHOW;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      SHOW: begin
        if (next_evt_s || clr_evt_s) begin
          state_d = LOAD_A;
          err_d   = 1'b0;
        end else begin
          state_d = SHOW;
        end
      end
      CLR_X:     state_d = from_b_q ? LOAD_B : LOAD_A;
      default:   state_d = LOAD_A;
    endcase
  end

  // Output values belonging to the state being entered, so they register with it.
  always_comb begin
    sel_d   = 2'b00;
    set_d   = 1'b0;
    rst_d   = 1'b0;
    start_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      LOAD_A:    sel_d = 2'b00;
      COMMIT_A:  set_d = 1'b1;
      LOAD_B:    sel_d = 2'b01;
      COMMIT_B: begin
        sel_d = 2'b01;
        set_d = 1'b1;
      end
      RUN_START: begin
        sel_d   = 2'b10;
        start_d = 1'b1;
        busy_d  = 1'b1;
      end
      RUN_WAIT: begin
        sel_d  = 2'b10;
        busy_d = 1'b1;
      end
      SHOW:      sel_d = 2'b10;
      CLR_X: begin
        sel_d = from_b_d ? 2'b01 : 2'b00;
        rst_d = 1'b1;
      end
      default:   sel_d = 2'b00;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= LOAD_A;
      tmo_q    <= '0;
      from_b_q <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= 2'b00;
      set_q    <= 1'b0;
      rst_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      from_b_q <= from_b_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      set_q    <= set_d;
      rst_q    <= rst_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign SW_SEL = sel_q;
  assign SET    = set_q;
  assign RESET  = rst_q;
  assign START  = start_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;
  assign STEP   = state_q;
endmodule
